// File: rtl/text_console.sv
// 80x30 character text console: text RAM with power-up/form-feed clear, a byte-stream
// cursor writer, and a 3-stage pixel pipeline (text RAM -> font ROM -> colour register).
module text_console #(
  parameter logic [23:0] FG           = 24'hFFFFFF,
  parameter logic [23:0] BG           = 24'h000080,
  parameter int          BLINK_FRAMES = 32
) (
  input  logic        clkp,
  input  logic        rst,
  input  logic [9:0]  px,
  input  logic [9:0]  py,
  input  logic        de,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  localparam int          CELLS     = 2400;
  localparam logic [11:0] LAST_ADDR = 12'd2399;
  localparam int          FC_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t      state_reg, state_next;
  logic [11:0] clr_addr_reg, clr_addr_next;
  logic [6:0]  cur_col_reg, cur_col_next;
  logic [4:0]  cur_row_reg, cur_row_next;
  logic [4:0]  row_inc;

  logic        ram_we;
  logic [11:0] ram_waddr;
  logic [7:0]  ram_wdata;
  logic [7:0]  text_ram [0:CELLS-1];

  // row*80 + col as shift-and-add; max 31*80+127 fits in 12 bits
  function automatic logic [11:0] cell_addr(input logic [6:0] col, input logic [4:0] row);
    return {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
  endfunction

  assign row_inc  = (cur_row_reg == 5'd29) ? 5'd0 : cur_row_reg + 5'd1;
  assign wr_ready = (state_reg == ST_IDLE);

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    cur_col_next  = cur_col_reg;
    cur_row_next  = cur_row_reg;
    ram_we        = 1'b0;
    ram_waddr     = clr_addr_reg;
    ram_wdata     = 8'h20;
    case (state_reg)
      ST_CLEAR: begin
        ram_we = 1'b1;
        if (clr_addr_reg == LAST_ADDR) begin
          state_next    = ST_IDLE;
          clr_addr_next = 12'd0;
        end else begin
          clr_addr_next = clr_addr_reg + 12'd1;
        end
      end
      ST_IDLE: begin
        if (wr_valid) begin
          if (wr_data >= 8'h20) begin
            ram_we    = 1'b1;
            ram_waddr = cell_addr(cur_col_reg, cur_row_reg);
            ram_wdata = wr_data;
            if (cur_col_reg == 7'd79) begin
              cur_col_next = 7'd0;
              cur_row_next = row_inc;
            end else begin
              cur_col_next = cur_col_reg + 7'd1;
            end
          end else begin
            case (wr_data)
              8'h0A: begin
                cur_col_next = 7'd0;
                cur_row_next = row_inc;
              end
              8'h0D: cur_col_next = 7'd0;
              8'h08: if (cur_col_reg != 7'd0) cur_col_next = cur_col_reg - 7'd1;
              8'h0C: begin
                cur_col_next  = 7'd0;
                cur_row_next  = 5'd0;
                clr_addr_next = 12'd0;
                state_next    = ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clkp) begin
    if (rst) begin
      state_reg    <= ST_CLEAR;
      clr_addr_reg <= 12'd0;
      cur_col_reg  <= 7'd0;
      cur_row_reg  <= 5'd0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
      cur_col_reg  <= cur_col_next;
      cur_row_reg  <= cur_row_next;
    end
  end

  // Stage 0: cell lookup; out-of-area pixels read address 0 to stay inside the array
  logic [6:0]  col0;
  logic [4:0]  row0;
  logic        in_area0, hit0;
  logic [11:0] rd_addr0;

  assign col0     = px[9:3];
  assign row0     = py[8:4];
  assign in_area0 = (px < 10'd640) && (py < 10'd480);
  assign rd_addr0 = in_area0 ? cell_addr(col0, row0) : 12'd0;
  assign hit0     = (col0 == cur_col_reg) && (row0 == cur_row_reg);

  logic [7:0] char_s1_reg;

  always_ff @(posedge clkp) begin
    if (ram_we && !rst) text_ram[ram_waddr] <= ram_wdata;
    char_s1_reg <= text_ram[rd_addr0];
  end

  logic       de_s1_reg, de_s2_reg, area_s1_reg, area_s2_reg, hit_s1_reg, hit_s2_reg;
  logic [2:0] bit_s1_reg, bit_s2_reg;
  logic [3:0] glyph_s1_reg;

  always_ff @(posedge clkp) begin
    if (rst) begin
      de_s1_reg    <= 1'b0;
      de_s2_reg    <= 1'b0;
      area_s1_reg  <= 1'b0;
      area_s2_reg  <= 1'b0;
      hit_s1_reg   <= 1'b0;
      hit_s2_reg   <= 1'b0;
      bit_s1_reg   <= 3'd0;
      bit_s2_reg   <= 3'd0;
      glyph_s1_reg <= 4'd0;
    end else begin
      de_s1_reg    <= de;
      de_s2_reg    <= de_s1_reg;
      area_s1_reg  <= in_area0;
      area_s2_reg  <= area_s1_reg;
      hit_s1_reg   <= hit0;
      hit_s2_reg   <= hit_s1_reg;
      bit_s1_reg   <= px[2:0];
      bit_s2_reg   <= bit_s1_reg;
      glyph_s1_reg <= py[3:0];
    end
  end

  assign font_addr = {char_s1_reg, glyph_s1_reg};

  // Blink: count rising edges of the (0,0) position so a held origin counts once
  logic            frame_hit, frame_hit_prev_reg, frame_start;
  logic [FC_W-1:0] frame_cnt_reg;
  logic            blink_reg;

  assign frame_hit   = (px == 10'd0) && (py == 10'd0);
  assign frame_start = frame_hit && !frame_hit_prev_reg;

  always_ff @(posedge clkp) begin
    if (rst) begin
      frame_hit_prev_reg <= 1'b0;
      frame_cnt_reg      <= '0;
      blink_reg          <= 1'b0;
    end else begin
      frame_hit_prev_reg <= frame_hit;
      if (frame_start) begin
        if (frame_cnt_reg == FC_LAST) begin
          frame_cnt_reg <= '0;
          blink_reg     <= ~blink_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + FC_W'(1);
        end
      end
    end
  end

  logic        pix_on, use_fg;
  logic [23:0] rgb_next, rgb_reg;

  assign pix_on   = font_data[3'd7 - bit_s2_reg];
  assign use_fg   = pix_on ^ (blink_reg & hit_s2_reg);
  assign rgb_next = (de_s2_reg && area_s2_reg) ? (use_fg ? FG : BG) : 24'h0;

  always_ff @(posedge clkp) begin
    if (rst) rgb_reg <= 24'h0;
    else     rgb_reg <= rgb_next;
  end

  logic [7:0] chan [3];
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign chan[gi] = rgb_reg[8*gi +: 8];
  end
  assign b = chan[0];
  assign g = chan[1];
  assign r = chan[2];

endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench for text_console: stimulus pushes expectations, monitors pop them
// on write handshakes and on delayed pixel/font-address strobes.
`timescale 1ns/1ps
module tb_text_console;

  localparam logic [23:0] FG_C = 24'hFFFFFF;
  localparam logic [23:0] BG_C = 24'h000080;
  localparam int          BF   = 32;

  logic        clkp = 1'b0;
  logic        rst;
  logic [9:0]  px, py;
  logic        de;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [11:0] font_addr;
  logic [7:0]  font_data = 8'h00;
  logic [7:0]  r, g, b;

  int total = 0;
  int bad   = 0;

  text_console #(.FG(FG_C), .BG(BG_C), .BLINK_FRAMES(BF)) dut (
    .clkp(clkp), .rst(rst), .px(px), .py(py), .de(de),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .font_addr(font_addr), .font_data(font_data), .r(r), .g(g), .b(b)
  );

  always #20 clkp = ~clkp;

  function automatic logic [7:0] rom(input logic [11:0] a);
    case (a[11:4])
      8'h41:   return 8'hF0;
      8'h58:   return 8'hAA;
      8'h20:   return 8'h00;
      default: return 8'h0F;
    endcase
  endfunction

  always @(posedge clkp) font_data <= rom(font_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: got %h", name, act);
    end
  endtask

  typedef struct { bit chk; int col; int row; } wexp_t;
  wexp_t       wq[$];
  logic [23:0] rgb_q[$];
  logic [11:0] fa_q[$];
  logic        rgb_now = 1'b0, fa_now = 1'b0, hs_d = 1'b0, fa_chk_d = 1'b0;
  logic [2:0]  rgb_chk_d = 3'b0;

  always @(posedge clkp) begin
    hs_d      <= wr_valid & wr_ready;
    fa_chk_d  <= fa_now;
    rgb_chk_d <= {rgb_chk_d[1:0], rgb_now};
  end

  always @(negedge clkp) begin
    if (hs_d) begin
      if (wq.size() == 0) check("wr_underflow", 32'd1, 32'd0);
      else begin
        wexp_t e;
        e = wq.pop_front();
        if (e.chk) begin
          check("cur_col", {25'b0, dut.cur_col_reg}, e.col);
          check("cur_row", {27'b0, dut.cur_row_reg}, e.row);
        end
      end
    end
    if (fa_chk_d) begin
      if (fa_q.size() == 0) check("fa_underflow", 32'd1, 32'd0);
      else check("font_addr", {20'b0, font_addr}, {20'b0, fa_q.pop_front()});
    end
    if (rgb_chk_d[2]) begin
      if (rgb_q.size() == 0) check("rgb_underflow", 32'd1, 32'd0);
      else check("rgb", {8'b0, r, g, b}, {8'b0, rgb_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clkp); #1;
  endtask

  task automatic idle();
    px = 10'd100; py = 10'd100; de = 1'b0; rgb_now = 1'b0; fa_now = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input bit d, input bit crgb,
                     input logic [23:0] ergb, input bit cfa, input logic [11:0] efa);
    px = 10'(x); py = 10'(y); de = d; rgb_now = crgb; fa_now = cfa;
    if (crgb) rgb_q.push_back(ergb);
    if (cfa) fa_q.push_back(efa);
    tick();
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  task automatic frame_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      px = 10'd0; py = 10'd0; tick();
      px = 10'd100; py = 10'd100; tick();
    end
  endtask

  task automatic send(input logic [7:0] d, input bit chk, input int ec, input int er);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_data = d;
    wq.push_back('{chk, ec, er});
    while (!wr_ready && n < 5000) begin tick(); n++; end
    if (n >= 5000) check("send_timeout", 32'd1, 32'd0);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic count_clear(input string name);
    int n;
    n = 0;
    while (!wr_ready && n < 3000) begin tick(); n++; end
    check(name, n, 2400);
  endtask

  task automatic dump_blank(input string name);
    int nb;
    nb = 0;
    for (int i = 0; i < 2400; i++) if (dut.text_ram[i] !== 8'h20) nb++;
    check(name, nb, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, want test done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
    px = 10'd100; py = 10'd100; de = 1'b1;
    repeat (5) tick();
    check("rst_wr_ready", {31'b0, wr_ready}, 0);
    check("rst_rgb", {8'b0, r, g, b}, 0);
    idle();

    // Release, interrupt the clear part-way, then let it run to completion
    rst = 1'b0;
    repeat (1000) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_mid_clear_ready", {31'b0, wr_ready}, 0);
    rst = 1'b0;
    count_clear("clear_len");
    dump_blank("clear_dump");

    // Blink on cursor cell (0,0) holding a space (glyph 0x00 -> BG unless swapped)
    pix(3, 5, 1, 1, BG_C, 1, 12'h205);
    drain();
    frame_pulses(BF - 1);
    pix(3, 5, 1, 1, BG_C, 0, 12'h0);
    drain();
    frame_pulses(1);
    pix(3, 5, 1, 1, FG_C, 0, 12'h0);
    pix(11, 5, 1, 1, BG_C, 0, 12'h0);
    drain();
    frame_pulses(BF);
    pix(3, 5, 1, 1, BG_C, 0, 12'h0);
    drain();

    // 'A' at (0,0) with ROM 0xF0: left half FG, right half BG
    send(8'h41, 1, 1, 0);
    for (int x = 0; x < 8; x++) pix(x, 0, 1, 1, (x < 4) ? FG_C : BG_C, 1, 12'h410);
    pix(8, 0, 1, 1, BG_C, 1, 12'h200);
    drain();

    // Blanking
    pix(640, 0, 1, 1, 24'h0, 0, 12'h0);
    pix(5, 2, 0, 1, 24'h0, 0, 12'h0);
    pix(5, 480, 1, 1, 24'h0, 0, 12'h0);
    drain();

    // Form feed with wr_valid held high; next byte waits for ready
    check("ff_ready_before", {31'b0, wr_ready}, 1);
    wr_valid = 1'b1; wr_data = 8'h0C;
    wq.push_back('{1'b1, 0, 0});
    tick();
    wr_data = 8'h0D;
    wq.push_back('{1'b1, 0, 0});
    count_clear("ff_clear_len");
    tick();
    wr_valid = 1'b0;
    dump_blank("ff_dump");

    // Fill the whole screen with 'X'
    for (int i = 0; i < 80; i++) send(8'h58, i == 79, 0, 1);
    for (int i = 0; i < 2320; i++) send(8'h58, i == 2319, 0, 0);
    check("ram_2399", {24'b0, dut.text_ram[2399]}, 32'h58);
    check("ram_0", {24'b0, dut.text_ram[0]}, 32'h58);
    pix(632, 464, 1, 1, FG_C, 1, 12'h580);
    pix(633, 464, 1, 1, BG_C, 1, 12'h580);
    pix(639, 479, 1, 1, BG_C, 1, 12'h58F);
    drain();

    // Control codes
    for (int i = 0; i < 3; i++) send(8'h0A, i == 2, 0, 3);
    for (int i = 0; i < 5; i++) send(8'h21, i == 4, 5, 3);
    send(8'h08, 1, 4, 3);
    send(8'h0D, 1, 0, 3);
    send(8'h08, 1, 0, 3);
    send(8'h0A, 1, 0, 4);
    check("bs_no_erase", {24'b0, dut.text_ram[244]}, 32'h21);
    for (int i = 0; i < 25; i++) send(8'h0A, i == 24, 0, 29);
    for (int i = 0; i < 7; i++) send(8'h21, i == 6, 7, 29);
    send(8'h0A, 1, 0, 0);
    send(8'h01, 1, 0, 0);
    send(8'h1B, 1, 0, 0);
    check("ram_2326", {24'b0, dut.text_ram[2326]}, 32'h21);
    check("ram_2327", {24'b0, dut.text_ram[2327]}, 32'h58);
    check("ram_0_kept", {24'b0, dut.text_ram[0]}, 32'h58);

    drain();
    check("wq_empty", wq.size(), 0);
    check("rgb_q_empty", rgb_q.size(), 0);
    check("fa_q_empty", fa_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
